rs_pool: RTL and testbench
==========================

Name: rs_pool

Overview:
Parametrised reservation station for the out-of-order core; successor to the single-port RS. It holds up to ENTRIES decoded ALU/branch ops between dispatch and the ALU. It captures operands from CDB_N result broadcast channels, including a same-cycle bypass at insertion. Each cycle it issues the lowest-index entry whose operands are both ready, and it clears all entries on a branch-mispredict flush.

Parameters:
ENTRIES, 16, number of station entries (power of two, >=2)
XLEN, 32, operand/immediate/pc width
ROB_W, 4, ROB tag width
OP_W, 6, opcode field width
CDB_N, 2, number of result broadcast channels (ALU, load/store)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rdy  in  1  global ready; low freezes the block
flush  in  1  mispredict clear
in_valid  in  1  dispatch request
in_qj_busy  in  1  operand j pending (tag in in_qj)
in_qj  in  ROB_W  producer tag j
in_vj  in  XLEN  value j (used when !in_qj_busy)
in_qk_busy  in  1  operand k pending
in_qk  in  ROB_W  producer tag k
in_vk  in  XLEN  value k
in_imm  in  XLEN  immediate
in_op  in  OP_W  opcode
in_dest  in  ROB_W  destination ROB tag
in_pc  in  XLEN  instruction pc
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_tag  in  CDB_N*ROB_W  channel c at [c*ROB_W +: ROB_W]
cdb_val  in  CDB_N*XLEN  channel c at [c*XLEN +: XLEN]
iss_ready  in  1  ALU can accept next cycle
full  out  1  count == ENTRIES
count  out  $clog2(ENTRIES)+1  occupied entries
iss_valid  out  1  issue output valid (one-cycle pulse per op)
iss_vj, iss_vk, iss_imm, iss_pc  out  XLEN  issued operands
iss_op  out  OP_W  issued opcode
iss_dest  out  ROB_W  issued destination tag

Behaviour:
- Reset (rst=0, async): all busy bits, count, and iss_* clear to 0; full=0.
- Per entry: busy, qj_busy, qj, vj, qk_busy, qk, vk, imm, op, dest, pc.
- All updates occur on posedge clk. When rdy=0: no insert, wakeup, or issue; iss_valid clears to 0; other state holds.
- Priority per edge: flush > {issue, wakeup, insert}.
- Flush: all busy=0, count=0, iss_valid=0; in_valid and CDB are ignored that cycle.
- Insert: accepted when in_valid && !full (full taken from registered count). Writes the lowest-index free entry. in_valid while full is dropped silently; the dispatcher must stall on full.
- Insert bypass: if in_qj_busy and some cdb_valid[c] has cdb_tag[c]==in_qj this cycle, store vj=cdb_val[c] and qj_busy=0. Same rule for k.
- Wakeup: each busy entry with qX_busy compares against all channels; on a match it captures the value and clears qX_busy. Multiple matching channels: lowest c wins.
- Issue select: uses registered state only. Same-cycle wakeups and inserts are not eligible. Candidate = busy && !qj_busy && !qk_busy; pick the lowest index.
- Issue: if iss_ready && a candidate exists, the iss_* registers load the entry, iss_valid=1, and entry busy=0 at the same edge. Otherwise iss_valid=0.
- Latency: operands ready at insert -> iss_valid 2 edges after the insert edge (insert edge, then select/issue edge). CDB wakeup -> iss_valid at the 2nd edge after the broadcast.
- count: +1 on accepted insert, -1 on issue; both in one cycle -> unchanged. A freed slot is reusable the following cycle.
- Slot reuse in the same cycle is not allowed: an insert never targets the entry being issued that edge.
- Tags are unsigned; no zero-tag special meaning. Readiness is carried only by the *_busy bits.

Test Plan:
1. Reset then insert op=0x01, both operands ready (vj=5, vk=7), iss_ready=1 -> iss_valid high exactly 2 edges later with vj=5, vk=7, dest as given; count returns 0.
2. Insert with qj_busy, qj=3; two cycles later drive cdb_valid=01, tag=3, val=0xDEAD -> iss_vj=0xDEAD, iss_valid on the 2nd edge after the broadcast.
3. Insert with qk=9 in the same cycle as channel 1 broadcasting tag 9 / val 0x42 -> captured at insert, issued 2 edges later with vk=0x42.
4. Fill 16 ready entries while iss_ready=0 -> full=1, count=16; a 17th in_valid is dropped. Then raise iss_ready -> issue order is entries 0,1,2,... one per cycle, and full drops after the first issue.
5. With 5 busy entries, assert flush together with in_valid and a matching CDB -> next cycle count=0, iss_valid=0, and nothing is issued afterwards.
6. Hold rdy=0 for 3 cycles with a ready entry and CDB activity -> no issue and no capture; after rdy=1 the entry issues normally. Assert rst mid-run -> outputs zero immediately (async).

Source files
------------

// File: rtl/rs_pool.sv
// Reservation station: holds dispatched ALU/branch ops, captures operands from the
// result broadcast channels (with insert-time bypass) and issues the lowest ready entry.
module rs_pool #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int CDB_N   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic                        in_qj_busy,
    input  logic [ROB_W-1:0]            in_qj,
    input  logic [XLEN-1:0]             in_vj,
    input  logic                        in_qk_busy,
    input  logic [ROB_W-1:0]            in_qk,
    input  logic [XLEN-1:0]             in_vk,
    input  logic [XLEN-1:0]             in_imm,
    input  logic [OP_W-1:0]             in_op,
    input  logic [ROB_W-1:0]            in_dest,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [CDB_N-1:0]            cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]      cdb_tag,
    input  logic [CDB_N*XLEN-1:0]       cdb_val,
    input  logic                        iss_ready,
    output logic                        full,
    output logic [$clog2(ENTRIES):0]    count,
    output logic                        iss_valid,
    output logic [XLEN-1:0]             iss_vj,
    output logic [XLEN-1:0]             iss_vk,
    output logic [XLEN-1:0]             iss_imm,
    output logic [XLEN-1:0]             iss_pc,
    output logic [OP_W-1:0]             iss_op,
    output logic [ROB_W-1:0]            iss_dest
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic              r_busy    [ENTRIES];
    logic              r_qj_busy [ENTRIES];
    logic [ROB_W-1:0]  r_qj      [ENTRIES];
    logic [XLEN-1:0]   r_vj      [ENTRIES];
    logic              r_qk_busy [ENTRIES];
    logic [ROB_W-1:0]  r_qk      [ENTRIES];
    logic [XLEN-1:0]   r_vk      [ENTRIES];
    logic [XLEN-1:0]   r_imm     [ENTRIES];
    logic [OP_W-1:0]   r_op      [ENTRIES];
    logic [ROB_W-1:0]  r_dest    [ENTRIES];
    logic [XLEN-1:0]   r_pc      [ENTRIES];
    logic [CNT_W-1:0]  r_count;

    logic              r_iss_valid;
    logic [XLEN-1:0]   r_iss_vj, r_iss_vk, r_iss_imm, r_iss_pc;
    logic [OP_W-1:0]   r_iss_op;
    logic [ROB_W-1:0]  r_iss_dest;

    logic              w_full;
    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_cand_found;
    logic [IDX_W-1:0]  w_cand_idx;
    logic              w_do_insert;
    logic              w_do_issue;
    logic              w_ins_qj_busy, w_ins_qk_busy;
    logic [XLEN-1:0]   w_ins_vj, w_ins_vk;
    logic              w_wk_qj_busy [ENTRIES];
    logic              w_wk_qk_busy [ENTRIES];
    logic [XLEN-1:0]   w_wk_vj      [ENTRIES];
    logic [XLEN-1:0]   w_wk_vk      [ENTRIES];

    assign w_full = (r_count == CNT_W'(ENTRIES));

    // Lowest-index free slot and lowest-index ready candidate, both from registered state;
    // the issued entry is busy, so an insert can never land on it in the same edge.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_cand_found = 1'b0;
        w_cand_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
                w_cand_found = 1'b1;
                w_cand_idx   = IDX_W'(i);
            end
        end
    end

    assign w_do_insert = in_valid && !w_full && w_free_found;
    assign w_do_issue  = iss_ready && w_cand_found;

    // Channel scans run high to low so the lowest matching channel ends up winning.
    always_comb begin
        w_ins_qj_busy = in_qj_busy;
        w_ins_vj      = in_vj;
        w_ins_qk_busy = in_qk_busy;
        w_ins_vk      = in_vk;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (in_qj_busy && cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == in_qj)) begin
                w_ins_qj_busy = 1'b0;
                w_ins_vj      = cdb_val[c*XLEN +: XLEN];
            end
            if (in_qk_busy && cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == in_qk)) begin
                w_ins_qk_busy = 1'b0;
                w_ins_vk      = cdb_val[c*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_wk_qj_busy[i] = r_qj_busy[i];
            w_wk_vj[i]      = r_vj[i];
            w_wk_qk_busy[i] = r_qk_busy[i];
            w_wk_vk[i]      = r_vk[i];
            for (int c = CDB_N - 1; c >= 0; c--) begin
                if (r_qj_busy[i] && cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == r_qj[i])) begin
                    w_wk_qj_busy[i] = 1'b0;
                    w_wk_vj[i]      = cdb_val[c*XLEN +: XLEN];
                end
                if (r_qk_busy[i] && cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == r_qk[i])) begin
                    w_wk_qk_busy[i] = 1'b0;
                    w_wk_vk[i]      = cdb_val[c*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_busy[i]    <= 1'b0;
                r_qj_busy[i] <= 1'b0;
                r_qj[i]      <= '0;
                r_vj[i]      <= '0;
                r_qk_busy[i] <= 1'b0;
                r_qk[i]      <= '0;
                r_vk[i]      <= '0;
                r_imm[i]     <= '0;
                r_op[i]      <= '0;
                r_dest[i]    <= '0;
                r_pc[i]      <= '0;
            end
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_vj    <= '0;
            r_iss_vk    <= '0;
            r_iss_imm   <= '0;
            r_iss_pc    <= '0;
            r_iss_op    <= '0;
            r_iss_dest  <= '0;
        end else if (!rdy) begin
            r_iss_valid <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_busy[i] <= 1'b0;
            end
            r_count     <= '0;
            r_iss_valid <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (r_busy[i]) begin
                    r_qj_busy[i] <= w_wk_qj_busy[i];
                    r_vj[i]      <= w_wk_vj[i];
                    r_qk_busy[i] <= w_wk_qk_busy[i];
                    r_vk[i]      <= w_wk_vk[i];
                end
            end
            r_iss_valid <= w_do_issue;
            if (w_do_issue) begin
                r_busy[w_cand_idx] <= 1'b0;
                r_iss_vj           <= r_vj[w_cand_idx];
                r_iss_vk           <= r_vk[w_cand_idx];
                r_iss_imm          <= r_imm[w_cand_idx];
                r_iss_pc           <= r_pc[w_cand_idx];
                r_iss_op           <= r_op[w_cand_idx];
                r_iss_dest         <= r_dest[w_cand_idx];
            end
            if (w_do_insert) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_qj_busy[w_free_idx] <= w_ins_qj_busy;
                r_qj[w_free_idx]      <= in_qj;
                r_vj[w_free_idx]      <= w_ins_vj;
                r_qk_busy[w_free_idx] <= w_ins_qk_busy;
                r_qk[w_free_idx]      <= in_qk;
                r_vk[w_free_idx]      <= w_ins_vk;
                r_imm[w_free_idx]     <= in_imm;
                r_op[w_free_idx]      <= in_op;
                r_dest[w_free_idx]    <= in_dest;
                r_pc[w_free_idx]      <= in_pc;
            end
            case ({w_do_insert, w_do_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full      = w_full;
    assign count     = r_count;
    assign iss_valid = r_iss_valid;
    assign iss_vj    = r_iss_vj;
    assign iss_vk    = r_iss_vk;
    assign iss_imm   = r_iss_imm;
    assign iss_pc    = r_iss_pc;
    assign iss_op    = r_iss_op;
    assign iss_dest  = r_iss_dest;
endmodule

// File: tb/tb_rs_pool.sv
// Bench for rs_pool: directed scenarios plus random traffic, checked cycle by cycle
// against an entry-list reference model and an expected-issue queue.
module tb_rs_pool;
    localparam int ENTRIES = 16;
    localparam int XLEN    = 32;
    localparam int ROB_W   = 4;
    localparam int OP_W    = 6;
    localparam int CDB_N   = 2;
    localparam int CNT_W   = 5;
    localparam int PW      = OP_W + ROB_W + 4*XLEN;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   rdy, flush, in_valid, in_qj_busy, in_qk_busy, iss_ready;
    logic [ROB_W-1:0]       in_qj, in_qk, in_dest;
    logic [XLEN-1:0]        in_vj, in_vk, in_imm, in_pc;
    logic [OP_W-1:0]        in_op;
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*ROB_W-1:0] cdb_tag;
    logic [CDB_N*XLEN-1:0]  cdb_val;
    logic                   full, iss_valid;
    logic [CNT_W-1:0]       count;
    logic [XLEN-1:0]        iss_vj, iss_vk, iss_imm, iss_pc;
    logic [OP_W-1:0]        iss_op;
    logic [ROB_W-1:0]       iss_dest;

    rs_pool #(.ENTRIES(ENTRIES), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid),
        .in_qj_busy(in_qj_busy), .in_qj(in_qj), .in_vj(in_vj),
        .in_qk_busy(in_qk_busy), .in_qk(in_qk), .in_vk(in_vk),
        .in_imm(in_imm), .in_op(in_op), .in_dest(in_dest), .in_pc(in_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .iss_ready(iss_ready), .full(full), .count(count), .iss_valid(iss_valid),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_op(iss_op), .iss_dest(iss_dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              busy;
        bit              jwait;
        logic [ROB_W-1:0] jtag;
        logic [XLEN-1:0] vj;
        bit              kwait;
        logic [ROB_W-1:0] ktag;
        logic [XLEN-1:0] vk;
        logic [XLEN-1:0] imm;
        logic [OP_W-1:0] op;
        logic [ROB_W-1:0] dest;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t           m_e [ENTRIES];
    bit             m_iss_valid;
    logic [PW-1:0]  exp_q [$];
    int             n_vec = 0;
    int             n_err = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        foreach (m_e[i]) if (m_e[i].busy) n++;
        return n;
    endfunction

    function automatic logic [PW-1:0] pack(input ent_t e);
        return {e.op, e.dest, e.pc, e.imm, e.vk, e.vj};
    endfunction

    // Lowest broadcasting channel carrying tag t, if any.
    function automatic bit cdb_hit(input logic [ROB_W-1:0] t, output logic [XLEN-1:0] v);
        v = '0;
        for (int c = 0; c < CDB_N; c++)
            if (cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == t) begin
                v = cdb_val[c*XLEN +: XLEN];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_reset();
        foreach (m_e[i]) m_e[i].busy = 1'b0;
        m_iss_valid = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the station, evaluated from the inputs currently driven.
    task automatic model_step();
        int sel = -1;
        int fr  = -1;
        bit was_full;
        logic [XLEN-1:0] v;
        ent_t n;
        if (!rdy) begin m_iss_valid = 1'b0; return; end
        if (flush) begin model_reset(); return; end
        was_full = (m_count() == ENTRIES);
        for (int i = 0; i < ENTRIES; i++)
            if (m_e[i].busy && !m_e[i].jwait && !m_e[i].kwait) begin sel = i; break; end
        for (int i = 0; i < ENTRIES; i++)
            if (!m_e[i].busy) begin fr = i; break; end
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_e[i].busy && m_e[i].jwait && cdb_hit(m_e[i].jtag, v)) begin m_e[i].jwait = 0; m_e[i].vj = v; end
            if (m_e[i].busy && m_e[i].kwait && cdb_hit(m_e[i].ktag, v)) begin m_e[i].kwait = 0; m_e[i].vk = v; end
        end
        m_iss_valid = iss_ready && (sel >= 0);
        if (m_iss_valid) begin
            exp_q.push_back(pack(m_e[sel]));
            m_e[sel].busy = 1'b0;
        end
        if (in_valid && !was_full) begin
            n.busy = 1'b1;
            n.jtag = in_qj; n.jwait = in_qj_busy; n.vj = in_vj;
            n.ktag = in_qk; n.kwait = in_qk_busy; n.vk = in_vk;
            if (in_qj_busy && cdb_hit(in_qj, v)) begin n.jwait = 0; n.vj = v; end
            if (in_qk_busy && cdb_hit(in_qk, v)) begin n.kwait = 0; n.vk = v; end
            n.imm = in_imm; n.op = in_op; n.dest = in_dest; n.pc = in_pc;
            m_e[fr] = n;
        end
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b1;
        in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_qj = '0; in_qk = '0;
        in_vj = '0; in_vk = '0; in_imm = '0; in_op = '0; in_dest = '0; in_pc = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic set_ins(input bit jb, input logic [ROB_W-1:0] qj, input logic [XLEN-1:0] vj,
                           input bit kb, input logic [ROB_W-1:0] qk, input logic [XLEN-1:0] vk,
                           input logic [OP_W-1:0] op, input logic [ROB_W-1:0] dest,
                           input logic [XLEN-1:0] pc);
        in_valid = 1'b1; in_qj_busy = jb; in_qj = qj; in_vj = vj;
        in_qk_busy = kb; in_qk = qk; in_vk = vk;
        in_imm = pc ^ 32'h5a5a_0000; in_op = op; in_dest = dest; in_pc = pc;
    endtask

    // Drive the current inputs across one edge, then compare against the model.
    task automatic cycle();
        logic [PW-1:0] e;
        model_step();
        @(posedge clk); #1;
        chk("iss_valid", PW'(iss_valid), PW'(m_iss_valid));
        chk("count", PW'(count), PW'(m_count()));
        chk("full", PW'(full), PW'(m_count() == ENTRIES));
        if (iss_valid) begin
            if (exp_q.size() == 0) chk("unexpected_issue", PW'(1), PW'(0));
            else begin
                e = exp_q.pop_front();
                chk("issue_payload", {iss_op, iss_dest, iss_pc, iss_imm, iss_vk, iss_vj}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b0;
        #1;
        chk("arst_iss_valid", PW'(iss_valid), PW'(0));
        chk("arst_count", PW'(count), PW'(0));
        chk("arst_full", PW'(full), PW'(0));
        chk("arst_iss_vj", PW'(iss_vj), PW'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_iss_valid", PW'(iss_valid), PW'(0));
        chk("rst_count", PW'(count), PW'(0));
        chk("rst_full", PW'(full), PW'(0));
        chk("rst_iss_dest", PW'(iss_dest), PW'(0));
        rst = 1'b1;
        @(negedge clk);

        // both operands ready at dispatch
        set_ins(0, 4'd0, 32'd5, 0, 4'd0, 32'd7, 6'h01, 4'd2, 32'h100);
        cycle(); idle();
        chk("t1_no_early_issue", PW'(iss_valid), PW'(0));
        cycle();
        chk("t1_valid", PW'(iss_valid), PW'(1));
        chk("t1_vj", PW'(iss_vj), PW'(5));
        chk("t1_vk", PW'(iss_vk), PW'(7));
        chk("t1_dest", PW'(iss_dest), PW'(2));
        cycle();

        // wakeup from channel 0
        set_ins(1, 4'd3, 32'd0, 0, 4'd0, 32'd11, 6'h02, 4'd4, 32'h104);
        cycle(); idle(); cycle();
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_val = {32'd0, 32'hDEAD};
        cycle(); idle();
        chk("t2_not_yet", PW'(iss_valid), PW'(0));
        cycle();
        chk("t2_valid", PW'(iss_valid), PW'(1));
        chk("t2_vj", PW'(iss_vj), PW'(32'hDEAD));

        // bypass at insert from channel 1
        set_ins(0, 4'd0, 32'd1, 1, 4'd9, 32'd0, 6'h03, 4'd6, 32'h108);
        cdb_valid = 2'b10; cdb_tag = {4'd9, 4'd0}; cdb_val = {32'h42, 32'd0};
        cycle(); idle(); cycle();
        chk("t3_vk", PW'(iss_vk), PW'(32'h42));

        // fill to full with issue blocked, then drain in index order
        for (int i = 0; i < ENTRIES + 1; i++) begin
            set_ins(0, 4'd0, XLEN'(i), 0, 4'd0, XLEN'(i * 3), 6'h04, ROB_W'(i), XLEN'(i * 4));
            iss_ready = 1'b0;
            cycle();
        end
        idle();
        for (int i = 0; i < ENTRIES; i++) begin
            cycle();
            chk("t4_order", PW'(iss_dest), PW'(i));
        end
        cycle();

        // flush beats insert and wakeup
        for (int i = 0; i < 5; i++) begin
            set_ins(1, 4'd7, 32'd0, 0, 4'd0, 32'd1, 6'h05, ROB_W'(i), XLEN'(i));
            iss_ready = 1'b0;
            cycle();
        end
        idle();
        flush = 1'b1;
        set_ins(0, 4'd0, 32'd1, 0, 4'd0, 32'd2, 6'h06, 4'd1, 32'h200);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_val = {32'd0, 32'hBEEF};
        cycle(); idle();
        chk("t5_count", PW'(count), PW'(0));
        repeat (3) cycle();

        // freeze with rdy low: no issue, no capture
        set_ins(0, 4'd0, 32'd8, 0, 4'd0, 32'd9, 6'h07, 4'd3, 32'h300);
        iss_ready = 1'b0;
        cycle();
        set_ins(1, 4'd5, 32'd0, 0, 4'd0, 32'd9, 6'h08, 4'd8, 32'h304);
        iss_ready = 1'b0;
        cycle(); idle();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_val = {32'h77, 32'h66};
            cycle();
        end
        idle();
        repeat (3) cycle();

        // random traffic with occasional flush, freeze and async reset
        for (int n = 0; n < 800; n++) begin
            idle();
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            iss_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 6)
                set_ins($urandom_range(0, 1), ROB_W'($urandom_range(0, 15)), $urandom,
                        $urandom_range(0, 1), ROB_W'($urandom_range(0, 15)), $urandom,
                        OP_W'($urandom), ROB_W'($urandom), $urandom);
            cdb_valid = CDB_N'($urandom_range(0, 3));
            cdb_tag   = CDB_N*ROB_W'($urandom);
            cdb_val   = {$urandom, $urandom};
            cycle();
            if (n == 400) async_reset_check();
        end
        idle();
        repeat (40) begin
            cdb_valid = 2'b11; cdb_tag = CDB_N*ROB_W'($urandom); cdb_val = {$urandom, $urandom};
            cycle();
        end
        chk("exp_q_drained", PW'(exp_q.size()), PW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
